pwm_duty_decoder: RTL and testbench

Receive-side counterpart to the 8-bit PWM audio generator: samples a single-bit PWM stream, recovers the 256-cycle frame from its rising edges, and reports the high-time count of each frame as an 8-bit sample. The block sits after a loopback or external PWM input in the audio path. It feeds recovered samples to the verification scoreboard and to any downstream sample consumer. It assumes the generator convention: the output is high for the first `x` cycles of each 256-cycle frame.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_input_sync.sv | 33 +++
 rtl/pwm_duty_decoder.sv | 117 +++++++++++
 tb/tb_pwm_duty_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty decoder and generator-side checks.
package pwm_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;

  function automatic int unsigned frame_len(input int unsigned w);
    return 32'd1 << w;
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DEF_WIDTH);

  // Clamp a high-sample count to the largest value a w-bit sample can carry.
  function automatic int unsigned sat_count(input int unsigned v, input int unsigned w);
    int unsigned max_v;
    max_v = frame_len(w) - 1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Synchronizer chain for the asynchronous PWM input plus rising-edge detect.
module pwm_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
    s_prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      s_prev_q <= s_prev_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers 2^WIDTH-cycle PWM frames from rising edges and reports each
// frame's high-time as a WIDTH-bit sample.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid_out,
  output logic             locked_out,
  output logic             err_out
);

  localparam int unsigned      LAST_POS = frame_len(WIDTH) - 1;
  localparam logic [WIDTH-1:0] POS_LAST = WIDTH'(LAST_POS);

  logic s, rise;

  pwm_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH:0]   hcnt_q, hcnt_d;
  logic [WIDTH:0]   hcnt_sum;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      hcnt_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hcnt_q   <= hcnt_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT:    if (rise) state_d = MEASURE;
      MEASURE: state_d = MEASURE;
      default: state_d = HUNT;
    endcase
  end

  assign hcnt_sum = hcnt_q + {{WIDTH{1'b0}}, s};

  // The sample taken at the last position is folded into the reported count,
  // so a full-high frame sums to 2^WIDTH and saturates.
  always_comb begin
    pos_d    = pos_q + WIDTH'(1);
    hcnt_d   = hcnt_sum;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (rise) begin
          pos_d  = WIDTH'(1);
          hcnt_d = (WIDTH+1)'(1);
        end else if (pos_q == POS_LAST) begin
          duty_d   = WIDTH'(sat_count(32'(hcnt_sum), WIDTH));
          valid_d  = 1'b1;
          locked_d = 1'b0;
          hcnt_d   = '0;
        end
      end
      MEASURE: begin
        // A misaligned edge takes precedence over the frame-end report.
        if (rise && (pos_q != '0)) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          pos_d    = WIDTH'(1);
          hcnt_d   = (WIDTH+1)'(1);
        end else if (pos_q == POS_LAST) begin
          duty_d   = WIDTH'(sat_count(32'(hcnt_sum), WIDTH));
          valid_d  = 1'b1;
          locked_d = 1'b1;
          hcnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign duty_out   = duty_q;
  assign valid_out  = valid_q;
  assign locked_out = locked_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: frame-window reference model over the sampled
// PWM stream, with per-scenario tasks.
module tb_pwm_duty_decoder;
  import pwm_pkg::*;

  logic       clk_in;
  logic       rst_in;
  logic       pwm_in;
  logic [7:0] duty_out;
  logic       valid_out;
  logic       locked_out;
  logic       err_out;

  pwm_duty_decoder #(
    .WIDTH      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .pwm_in    (pwm_in),
    .duty_out  (duty_out),
    .valid_out (valid_out),
    .locked_out(locked_out),
    .err_out   (err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int unsigned cmp_n;
  int unsigned fail_n;
  int unsigned gen_cnt;
  int unsigned phase;

  // Reference model: stream of samples the decoder sees (two reset zeros
  // ahead of the driven values), and the samples of the frame in progress.
  logic       m_hq[$];
  logic       m_frame[$];
  logic       m_prev;
  bit         m_meas;
  logic       e_valid, e_err, e_locked;
  logic [7:0] e_duty;

  function automatic void model_update(input logic r, input logic p);
    logic s, rise;
    int unsigned sum;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (r) begin
      m_hq.delete();
      m_hq.push_back(1'b0);
      m_hq.push_back(1'b0);
      m_frame.delete();
      m_prev   = 1'b0;
      m_meas   = 1'b0;
      e_duty   = 8'd0;
      e_locked = 1'b0;
      return;
    end
    m_hq.push_back(p);
    s      = m_hq.pop_front();
    rise   = s & ~m_prev;
    m_prev = s;
    if (rise && !m_meas) begin
      m_meas = 1'b1;
      m_frame.delete();
      m_frame.push_back(s);
    end else if (rise && m_frame.size() != 0) begin
      e_err    = 1'b1;
      e_locked = 1'b0;
      m_frame.delete();
      m_frame.push_back(s);
    end else begin
      m_frame.push_back(s);
      if (m_frame.size() == FRAME_LEN) begin
        sum = 0;
        foreach (m_frame[i]) if (m_frame[i]) sum++;
        e_valid  = 1'b1;
        e_duty   = 8'((sum > 255) ? 255 : sum);
        e_locked = m_meas;
        m_frame.delete();
      end
    end
  endfunction

  // Called at posedge+1; drives inputs at posedge+phase, returns at next posedge+1.
  task automatic step(input logic r, input logic p);
    if (phase > 1) #(phase - 1);
    rst_in = r;
    pwm_in = p;
    @(posedge clk_in);
    #1;
    model_update(r, p);
  endtask

  task automatic gen_cycle(input int unsigned x, input int unsigned hole);
    step(1'b0, (gen_cnt < x) && (gen_cnt != hole));
    gen_cnt = (gen_cnt + 1) % FRAME_LEN;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      cmp_n++;
      if ({valid_out, err_out, locked_out, duty_out} !== 11'd0) begin
        fail_n++;
        $display("FAIL reset_state got v%b e%b l%b d%0d want all zero",
                 valid_out, err_out, locked_out, duty_out);
      end
    end
    gen_cnt = 0;
  endtask

  task automatic test_constant();
    int unsigned nvalid = 0, nerr = 0;
    for (int i = 0; i < 5 * 256; i++) begin
      gen_cycle(100, 256);
      cmp_n++;
      if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
        fail_n++;
        $display("FAIL const100 t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", $time,
                 valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
      end
      if (err_out) nerr++;
      if (valid_out) begin
        nvalid++;
        cmp_n++;
        if (duty_out !== 8'd100 || locked_out !== 1'b1) begin
          fail_n++;
          $display("FAIL const100_value got d%0d l%b want d100 l1", duty_out, locked_out);
        end
      end
    end
    cmp_n++;
    if (nvalid != 4 || nerr != 0) begin
      fail_n++;
      $display("FAIL const100_count got valids=%0d errs=%0d want valids=4 errs=0", nvalid, nerr);
    end
  endtask

  task automatic test_sweep();
    int unsigned xs[$];
    int unsigned last_duty, nerr;
    for (int v = 0; v < 256; v += 17) xs.push_back(v);
    xs.push_back(1);
    xs.push_back(254);
    xs.push_back(255);
    nerr = 0;
    foreach (xs[k]) begin
      last_duty = 999;
      for (int i = 0; i < 2 * 256; i++) begin
        gen_cycle(xs[k], 256);
        cmp_n++;
        if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
          fail_n++;
          $display("FAIL sweep x=%0d t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", xs[k], $time,
                   valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
        end
        if (valid_out) last_duty = duty_out;
        if (err_out) nerr++;
      end
      cmp_n++;
      if (last_duty != xs[k] || locked_out !== 1'b1) begin
        fail_n++;
        $display("FAIL sweep_value x=%0d got d%0d l%b want d%0d l1", xs[k], last_duty, locked_out, xs[k]);
      end
    end
    cmp_n++;
    if (nerr != 0) begin
      fail_n++;
      $display("FAIL sweep_err got errs=%0d want 0", nerr);
    end
  endtask

  task automatic test_misaligned_edge();
    int unsigned nerr = 0;
    bit saw_unlock = 0, both = 0;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 256; i++) begin
        gen_cycle(60, (f == 2) ? 39 : 256);
        cmp_n++;
        if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
          fail_n++;
          $display("FAIL misaligned t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", $time,
                   valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
        end
        if (err_out) nerr++;
        if (err_out && valid_out) both = 1;
        if (nerr > 0 && !locked_out) saw_unlock = 1;
      end
    end
    cmp_n++;
    if (nerr == 0 || !saw_unlock || both) begin
      fail_n++;
      $display("FAIL misaligned_flags got errs=%0d unlock=%0d err_with_valid=%0d want errs>0 unlock=1 err_with_valid=0",
               nerr, saw_unlock, both);
    end
    cmp_n++;
    if (duty_out !== 8'd60 || locked_out !== 1'b1) begin
      fail_n++;
      $display("FAIL misaligned_relock got d%0d l%b want d60 l1", duty_out, locked_out);
    end
  endtask

  task automatic test_reset_midstream();
    int unsigned first_duty = 999;
    for (int i = 0; i < 256 + 128; i++) gen_cycle(80, 256);
    step(1'b1, gen_cnt < 80);
    gen_cnt = (gen_cnt + 1) % FRAME_LEN;
    cmp_n++;
    if ({valid_out, err_out, locked_out, duty_out} !== 11'd0) begin
      fail_n++;
      $display("FAIL midreset_clear got v%b e%b l%b d%0d want all zero",
               valid_out, err_out, locked_out, duty_out);
    end
    for (int i = 0; i < 127 + 3 * 256; i++) begin
      gen_cycle(80, 256);
      cmp_n++;
      if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
        fail_n++;
        $display("FAIL midreset t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", $time,
                 valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
      end
      if (valid_out && first_duty == 999) first_duty = duty_out;
    end
    cmp_n++;
    if (first_duty != 80 || locked_out !== 1'b1) begin
      fail_n++;
      $display("FAIL midreset_relock got first d%0d l%b want d80 l1", first_duty, locked_out);
    end
  endtask

  task automatic test_jitter();
    int unsigned x, fj;
    phase = $urandom_range(1, 9);
    x     = $urandom_range(20, 230);
    fj    = 0;
    for (int i = 0; i < 6 * 256; i++) begin
      if (gen_cnt == 0) fj = $urandom_range(0, 1);
      gen_cycle(x + fj, 256);
      cmp_n++;
      if ($isunknown({valid_out, err_out, locked_out, duty_out}) ||
          {valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
        fail_n++;
        $display("FAIL jitter x=%0d t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", x, $time,
                 valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
      end
      if (valid_out && i > 8) begin
        cmp_n++;
        if (duty_out + 1 < x || duty_out > x + 1) begin
          fail_n++;
          $display("FAIL jitter_range got d%0d want %0d..%0d", duty_out, x - 1, x + 1);
        end
      end
    end
    phase = 1;
  endtask

  task automatic test_constant_high();
    int unsigned nvalid = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 800; i++) begin
      step(1'b0, 1'b1);
      cmp_n++;
      if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
        fail_n++;
        $display("FAIL const_high t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", $time,
                 valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
      end
      if (valid_out) begin
        nvalid++;
        cmp_n++;
        if (duty_out !== 8'd255 || locked_out !== 1'b1) begin
          fail_n++;
          $display("FAIL const_high_value got d%0d l%b want d255 l1", duty_out, locked_out);
        end
      end
    end
    cmp_n++;
    if (nvalid != 3) begin
      fail_n++;
      $display("FAIL const_high_count got %0d want 3", nvalid);
    end
  endtask

  task automatic test_timeout();
    int unsigned nvalid = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 1'b0);
      cmp_n++;
      if ({valid_out, err_out, locked_out, duty_out} !== {e_valid, e_err, e_locked, e_duty}) begin
        fail_n++;
        $display("FAIL timeout t=%0t got v%b e%b l%b d%0d want v%b e%b l%b d%0d", $time,
                 valid_out, err_out, locked_out, duty_out, e_valid, e_err, e_locked, e_duty);
      end
      if (valid_out) begin
        nvalid++;
        cmp_n++;
        if (duty_out !== 8'd0 || locked_out !== 1'b0) begin
          fail_n++;
          $display("FAIL timeout_value got d%0d l%b want d0 l0", duty_out, locked_out);
        end
      end
    end
    cmp_n++;
    if (nvalid != 2) begin
      fail_n++;
      $display("FAIL timeout_count got %0d want 2", nvalid);
    end
  endtask

  initial begin
    cmp_n   = 0;
    fail_n  = 0;
    gen_cnt = 0;
    phase   = 1;
    rst_in  = 1'b1;
    pwm_in  = 1'b0;
    @(posedge clk_in);
    #1;
    test_reset();
    test_constant();
    test_sweep();
    test_misaligned_edge();
    test_reset_midstream();
    test_jitter();
    test_constant_high();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
